// File: rtl/sbox_step2_inv_anf.sv
// Masked (2-share) inverse of the Skinny S-box step-2 ANF slice.
// The first stage undoes the affine output layer share-wise, with the constant
// added to share 0 only. The second stage is a registered DOM-style masked NOR
// that uses one fresh random bit. An optional share register sits between
// the two stages. Valid/ready handshakes on both sides allow full-throughput
// stalling.
module sbox_step2_inv_anf #(
  parameter int PIPELINE            = 0,
  parameter bit SHARE_ZERO_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out0,
  output logic [3:0] out1
);

  // Linear part of the affine inverse, returned as {a3, a2, a1, a0} without the constant.
  function automatic logic [3:0] f_lin(input logic [3:0] y);
    logic [3:0] a;
    a[3] = y[1] ^ y[2] ^ y[3];
    a[2] = y[0] ^ y[1];
    a[1] = y[3] ^ y[0] ^ y[1];
    a[0] = y[0] ^ y[1] ^ y[2] ^ y[3];
    return a;
  endfunction

  // Share-wise affine inverse: the constant on bit 1 goes into share 0 only.
  logic [3:0] w_a0, w_a1;
  assign w_a0 = f_lin(in0) ^ 4'b0010;
  assign w_a1 = f_lin(in1);

  // Word that feeds the gadget stage (direct from the affine stage or from its register).
  logic [3:0] w_src0, w_src1;
  logic       w_src_vld;

  // Gadget stage state.
  logic       r_g_vld;
  logic [3:0] r_g_a0, r_g_a1;
  logic       r_g_p00, r_g_p11, r_g_p01, r_g_p10;
  logic       w_g_free, w_g_ld;

  // The gadget stage can take a new word when it is empty or its word is leaving.
  assign w_g_free = ~r_g_vld | out_ready;
  assign w_g_ld   = w_g_free & w_src_vld;

  generate
    if (PIPELINE != 0) begin : g_pipe
      logic       r_s1_vld;
      logic [3:0] r_s1_a0, r_s1_a1;
      logic       w_s1_ld;

      assign in_ready  = ~r_s1_vld | w_g_free;
      assign w_s1_ld   = in_ready & in_valid;
      assign w_src0    = r_s1_a0;
      assign w_src1    = r_s1_a1;
      assign w_src_vld = r_s1_vld;

      // Stage-1 valid flag: refills whenever the stage is empty or advancing.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_vld <= 1'b0;
        end else if (in_ready) begin
          r_s1_vld <= in_valid;
        end
      end

      if (SHARE_ZERO_ON_RESET) begin : g_s1_rst
        // Stage-1 share register, cleared on reset.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_s1_a0 <= 4'h0;
            r_s1_a1 <= 4'h0;
          end else if (w_s1_ld) begin
            r_s1_a0 <= w_a0;
            r_s1_a1 <= w_a1;
          end
        end
      end else begin : g_s1_nrst
        // Stage-1 share register, data left unreset.
        always_ff @(posedge clk) begin
          if (w_s1_ld) begin
            r_s1_a0 <= w_a0;
            r_s1_a1 <= w_a1;
          end
        end
      end
    end else begin : g_nopipe
      assign in_ready  = w_g_free;
      assign w_src0    = w_a0;
      assign w_src1    = w_a1;
      assign w_src_vld = in_valid;
    end
  endgenerate

  // Masked NOR inputs: x = ~a3, w = ~a2, complementing share 0 only.
  logic w_x0, w_w0, w_x1, w_w1;
  logic w_p00, w_p11, w_p01, w_p10;
  assign w_x0  = ~w_src0[3];
  assign w_w0  = ~w_src0[2];
  assign w_x1  = w_src1[3];
  assign w_w1  = w_src1[2];
  // Cross-share products are refreshed with r and registered before any recombination.
  assign w_p00 = w_x0 & w_w0;
  assign w_p11 = w_x1 & w_w1;
  assign w_p01 = (w_x0 & w_w1) ^ r;
  assign w_p10 = (w_x1 & w_w0) ^ r;

  // Gadget valid flag: follows the upstream valid whenever the stage can take a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_vld <= 1'b0;
    end else if (w_g_free) begin
      r_g_vld <= w_src_vld;
    end
  end

  generate
    if (SHARE_ZERO_ON_RESET) begin : g_g_rst
      // Gadget share/product register, cleared on reset; r is sampled only on load.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_g_a0  <= 4'h0;
          r_g_a1  <= 4'h0;
          r_g_p00 <= 1'b0;
          r_g_p11 <= 1'b0;
          r_g_p01 <= 1'b0;
          r_g_p10 <= 1'b0;
        end else if (w_g_ld) begin
          r_g_a0  <= w_src0;
          r_g_a1  <= w_src1;
          r_g_p00 <= w_p00;
          r_g_p11 <= w_p11;
          r_g_p01 <= w_p01;
          r_g_p10 <= w_p10;
        end
      end
    end else begin : g_g_nrst
      // Gadget share/product register, data left unreset; r is sampled only on load.
      always_ff @(posedge clk) begin
        if (w_g_ld) begin
          r_g_a0  <= w_src0;
          r_g_a1  <= w_src1;
          r_g_p00 <= w_p00;
          r_g_p11 <= w_p11;
          r_g_p01 <= w_p01;
          r_g_p10 <= w_p10;
        end
      end
    end
  endgenerate

  // Outputs come only from gadget registers; the products recombine within each share.
  assign out_valid = r_g_vld;
  assign out0      = {r_g_a0[3:1], r_g_a0[0] ^ r_g_p00 ^ r_g_p01};
  assign out1      = {r_g_a1[3:1], r_g_a1[0] ^ r_g_p11 ^ r_g_p10};

endmodule

// File: tb/tb_sbox_step2_inv_anf.sv
// Scoreboard bench for sbox_step2_inv_anf: one instance per PIPELINE setting,
// selected by 'sel', sharing stimulus and a single output monitor.
module tb_sbox_step2_inv_anf;

  typedef struct {
    logic [3:0] e0, e1;   // expected shares with the r that was driven
    logic [3:0] f0, f1;   // expected shares with r flipped
    logic [3:0] ez;       // expected unmasked result
    int         acc;      // cycle count at acceptance
    bit         lat;      // check latency for this word
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in0 = 4'h0, in1 = 4'h0;
  logic       rnd = 1'b0;
  logic       out_ready = 1'b1;

  logic       ir0, ir1, ov0, ov1;
  logic [3:0] o00, o01, o10, o11;

  logic       w_in_ready, w_out_valid;
  logic [3:0] w_out0, w_out1;

  int   n_tot = 0, n_bad = 0, cyc = 0, nout = 0;
  ent_t q[$];
  logic [3:0] last_o0 = 4'h0, last_o1 = 4'h0, prev_o0 = 4'h0, prev_o1 = 4'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox_step2_inv_anf #(.PIPELINE(0), .SHARE_ZERO_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir0),
    .in0(in0), .in1(in1), .r(rnd), .out_valid(ov0), .out_ready(out_ready),
    .out0(o00), .out1(o01)
  );

  sbox_step2_inv_anf #(.PIPELINE(1), .SHARE_ZERO_ON_RESET(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir1),
    .in0(in0), .in1(in1), .r(rnd), .out_valid(ov1), .out_ready(out_ready),
    .out0(o10), .out1(o11)
  );

  assign w_in_ready  = sel ? ir1 : ir0;
  assign w_out_valid = sel ? ov1 : ov0;
  assign w_out0      = sel ? o10 : o00;
  assign w_out1      = sel ? o11 : o01;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Unmasked reference, straight from the function definition.
  function automatic logic [3:0] zref(input logic [3:0] y);
    logic a3, a2, a1, a0;
    a2 = y[0] ^ y[1];
    a1 = y[3] ^ y[0] ^ y[1] ^ 1'b1;
    a0 = y[0] ^ y[1] ^ y[2] ^ y[3];
    a3 = y[1] ^ y[2] ^ y[3];
    return {a3, a2, a1, a0 ^ ~(a3 | a2)};
  endfunction

  // Share-level model of the masked datapath: returns {out0, out1}.
  function automatic logic [7:0] mshare(input logic [3:0] s0, input logic [3:0] s1, input logic rr);
    logic [3:0] b0, b1;
    logic x0, w0, x1, w1, p00, p11, p01, p10;
    b0 = {s0[1] ^ s0[2] ^ s0[3], s0[0] ^ s0[1], ~(s0[3] ^ s0[0] ^ s0[1]), s0[0] ^ s0[1] ^ s0[2] ^ s0[3]};
    b1 = {s1[1] ^ s1[2] ^ s1[3], s1[0] ^ s1[1],   s1[3] ^ s1[0] ^ s1[1],  s1[0] ^ s1[1] ^ s1[2] ^ s1[3]};
    x0 = ~b0[3]; w0 = ~b0[2]; x1 = b1[3]; w1 = b1[2];
    p00 = x0 & w0; p11 = x1 & w1;
    p01 = (x0 & w1) ^ rr; p10 = (x1 & w0) ^ rr;
    return {b0[3:1], b0[0] ^ p00 ^ p01, b1[3:1], b1[0] ^ p11 ^ p10};
  endfunction

  // Drive one word until accepted; push its expectation at the accepting edge.
  task automatic send(input logic [3:0] y, input logic [3:0] s0, input logic rr, input bit lat);
    ent_t e;
    logic [7:0] m, mf;
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in0 = s0; in1 = y ^ s0; rnd = rr;
    m  = mshare(s0, y ^ s0, rr);
    mf = mshare(s0, y ^ s0, ~rr);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (w_in_ready) begin
        e.e0 = m[7:4]; e.e1 = m[3:0]; e.f0 = mf[7:4]; e.f1 = mf[3:0];
        e.ez = zref(y); e.acc = cyc; e.lat = lat;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", {31'd0, w_in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: compares the head of the scoreboard every cycle the output is valid.
  always @(negedge clk) begin
    if (rst_n && w_out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'd0, w_out_valid}, 32'd0);
      end else begin
        ent_t e;
        logic [7:0] exp_sh;
        e = q[0];
        exp_sh = (sel == 1'b0 || w_out0[0] == e.e0[0]) ? {e.e0, e.e1} : {e.f0, e.f1};
        chk("shares", {w_out0, w_out1}, exp_sh);
        chk("unmasked", w_out0 ^ w_out1, e.ez);
        if (out_ready) begin
          if (e.lat) chk("latency", cyc, e.acc + 1 + int'(sel));
          void'(q.pop_front());
          nout++;
          prev_o0 = last_o0; prev_o1 = last_o1;
          last_o0 = w_out0;  last_o1 = w_out1;
        end
      end
    end
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", w_out_valid, 0);
    chk("rst_in_ready", w_in_ready, 1);
    chk("rst_out0", w_out0, 0);
    chk("rst_out1", w_out1, 0);
    @(posedge clk); #1;

    // Directed values, PIPELINE=0
    send(4'h0, 4'h0, 1'b0, 1'b1);
    send(4'hF, 4'hA, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send(4'hF, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Masking sanity: same y and split, only r toggled
    send(4'h6, 4'h3, 1'b0, 1'b0);
    send(4'h6, 4'h3, 1'b1, 1'b0);
    drain();
    chk("mask_r_out0", last_o0 ^ prev_o0, 4'h1);
    chk("mask_r_unmasked", (last_o0 ^ last_o1) ^ (prev_o0 ^ prev_o1), 4'h0);

    // Exhaustive y with random masks, both pipeline depths
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int y = 0; y < 16; y++) send(4'(y), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      drain();
    end

    // 20-word stream with a 3-cycle output stall, both pipeline depths
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      n0 = nout;
      fork
        begin
          for (int i = 0; i < 20; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        end
        begin
          repeat (5) @(posedge clk);
          #1 out_ready = 1'b0;
          repeat (2) @(posedge clk);
          @(negedge clk);
          chk("stall_in_ready", w_in_ready, 0);
          @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
      drain();
      chk("stream_count", nout - n0, 20);
    end

    // Reset with two words in flight (PIPELINE=1)
    sel = 1'b1;
    out_ready = 1'b0;
    send(4'h3, 4'h9, 1'b1, 1'b0);
    send(4'hC, 4'h5, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", w_out_valid, 0);
    chk("async_rst_in_ready", w_in_ready, 1);
    chk("async_rst_out0", w_out0, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n0 = nout;
    send(4'h7, 4'h2, 1'b0, 1'b1);
    send(4'h1, 4'hE, 1'b1, 1'b1);
    drain();
    chk("post_rst_count", nout - n0, 2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
